// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU control slice: controller state encoding,
// instruction class produced by the decoder, opcode and ALU-op constants and
// a small helper for the conditional-jump rule.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Encoding is externally visible on the debug state port.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_JUMP  = 3'd3,
    CLS_HALT  = 3'd4
  } op_class_t;

  // Opcodes (instr[15:12])
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'hC;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_JUMP  = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU operation codes; immediate forms reuse their opcode as the ALU op.
  localparam logic [3:0] ALU_NOP       = 4'h0;
  localparam logic [3:0] ALU_IMM_FIRST = 4'h1;
  localparam logic [3:0] ALU_IMM_LAST  = 4'hB;

  // instr[11] = 0 : unconditional; instr[11] = 1 : taken only on zero flag.
  function automatic logic jump_taken(input logic cond_bit, input logic zero);
    return !cond_bit || zero;
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm_if
// Bundle between the control FSM and the datapath/memory side.
//   Datapath -> FSM : instr, mem_ready, zero_flag, run
//   FSM -> datapath : ir_wen, pc_en, pc_sel, mem_rd, mem_wr, addr_sel, rf_wen,
//                     wb_sel, imm_sel, alu_op, halted, fault, state
// master = control FSM side, slave = datapath side.
// -----------------------------------------------------------------------------
interface cpu_control_fsm_if;
  logic [15:0] instr;
  logic        mem_ready;
  logic        zero_flag;
  logic        run;

  logic        ir_wen;
  logic        pc_en;
  logic        pc_sel;
  logic        mem_rd;
  logic        mem_wr;
  logic        addr_sel;
  logic        rf_wen;
  logic        wb_sel;
  logic        imm_sel;
  logic [3:0]  alu_op;
  logic        halted;
  logic        fault;
  logic [2:0]  state;

  modport master (
    input  instr, mem_ready, zero_flag, run,
    output ir_wen, pc_en, pc_sel, mem_rd, mem_wr, addr_sel, rf_wen, wb_sel,
           imm_sel, alu_op, halted, fault, state
  );

  modport slave (
    output instr, mem_ready, zero_flag, run,
    input  ir_wen, pc_en, pc_sel, mem_rd, mem_wr, addr_sel, rf_wen, wb_sel,
           imm_sel, alu_op, halted, fault, state
  );
endinterface

// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational instruction decode.
//   i_opcode  : instr[15:12]
//   i_funct   : instr[7:4], ALU op for R-type
//   o_class   : ALU / LOAD / STORE / JUMP / HALT
//   o_alu_op  : ALU operation (funct for R-type, opcode for immediate forms)
//   o_imm_sel : ALU operand B from immediate
// -----------------------------------------------------------------------------
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic [3:0] i_funct,
  output op_class_t  o_class,
  output logic [3:0] o_alu_op,
  output logic       o_imm_sel
);

  always_comb begin
    o_class   = CLS_ALU;
    o_alu_op  = ALU_NOP;
    o_imm_sel = 1'b0;
    if (i_opcode == OP_RTYPE) begin
      o_alu_op = i_funct;
    end else if (i_opcode >= ALU_IMM_FIRST && i_opcode <= ALU_IMM_LAST) begin
      o_alu_op  = i_opcode;
      o_imm_sel = 1'b1;
    end else begin
      case (i_opcode)
        OP_LOAD:  o_class = CLS_LOAD;
        OP_STORE: o_class = CLS_STORE;
        OP_JUMP:  o_class = CLS_JUMP;
        OP_HALT:  o_class = CLS_HALT;
        default:  o_class = CLS_ALU;
      endcase
    end
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Multi-cycle CPU controller: FETCH -> DECODE -> EXEC [-> MEM] -> FETCH, with
// HALT (left by a run pulse) and FAULT (left only by reset) states. Memory
// accesses in FETCH and MEM are bounded by an 8-bit wait counter.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   ctl_if : master side of cpu_control_fsm_if (instr/mem_ready/zero_flag/run
//            in, control strobes and status out)
// Parameter MEM_TIMEOUT (1..255): wait cycles tolerated per memory access.
// -----------------------------------------------------------------------------
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  cpu_control_fsm_if.master ctl_if
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     r_state;
  logic [7:0] r_wait_cnt;

  state_t     w_next;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic       w_timeout;

  op_class_t  w_class;
  logic [3:0] w_dec_alu_op;
  logic       w_dec_imm_sel;

  logic       w_ir_wen, w_pc_en, w_pc_sel, w_mem_rd, w_mem_wr, w_addr_sel;
  logic       w_rf_wen, w_wb_sel, w_imm_sel, w_halted, w_fault;
  logic [3:0] w_alu_op;

  // instr bits that carry operands for the datapath only.
  logic       w_unused_bits;
  assign w_unused_bits = ^{ctl_if.instr[10:8], ctl_if.instr[3:0]};

  instr_decode u_decode (
    .i_opcode  (ctl_if.instr[15:12]),
    .i_funct   (ctl_if.instr[7:4]),
    .o_class   (w_class),
    .o_alu_op  (w_dec_alu_op),
    .o_imm_sel (w_dec_imm_sel)
  );

  // The counter holds k on the k-th wait cycle of an access. A wait cycle at
  // k == MEM_TIMEOUT faults, while mem_ready on that same cycle still succeeds.
  assign w_timeout = (r_wait_cnt == TIMEOUT_CNT);

  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_ir_wen   = 1'b0;
    w_pc_en    = 1'b0;
    w_pc_sel   = 1'b0;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_addr_sel = 1'b0;
    w_rf_wen   = 1'b0;
    w_wb_sel   = 1'b0;
    w_imm_sel  = 1'b0;
    w_alu_op   = ALU_NOP;
    w_halted   = 1'b0;
    w_fault    = 1'b0;

    case (r_state)
      ST_FETCH: begin
        w_mem_rd = 1'b1;
        if (ctl_if.mem_ready) begin
          w_ir_wen = 1'b1;
          w_pc_en  = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_timeout) begin
          w_next = ST_FAULT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      ST_DECODE: w_next = ST_EXEC;

      ST_EXEC: begin
        case (w_class)
          CLS_ALU: begin
            w_rf_wen  = 1'b1;
            w_alu_op  = w_dec_alu_op;
            w_imm_sel = w_dec_imm_sel;
            w_next    = ST_FETCH;
            w_cnt_clr = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            w_next    = ST_MEM;
            w_cnt_clr = 1'b1;
          end
          CLS_JUMP: begin
            if (jump_taken(ctl_if.instr[11], ctl_if.zero_flag)) begin
              w_pc_en  = 1'b1;
              w_pc_sel = 1'b1;
            end
            w_next    = ST_FETCH;
            w_cnt_clr = 1'b1;
          end
          CLS_HALT: w_next = ST_HALT;
          default:  w_next = ST_FAULT;
        endcase
      end

      ST_MEM: begin
        w_addr_sel = 1'b1;
        w_mem_rd   = (w_class == CLS_LOAD);
        w_mem_wr   = (w_class == CLS_STORE);
        if (ctl_if.mem_ready) begin
          w_rf_wen  = (w_class == CLS_LOAD);
          w_wb_sel  = (w_class == CLS_LOAD);
          w_next    = ST_FETCH;
          w_cnt_clr = 1'b1;
        end else if (w_timeout) begin
          w_next = ST_FAULT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      ST_HALT: begin
        w_halted = 1'b1;
        if (ctl_if.run) begin
          w_next    = ST_FETCH;
          w_cnt_clr = 1'b1;
        end
      end

      ST_FAULT: w_fault = 1'b1;

      default: w_next = ST_FAULT;
    endcase

    // Strobes are combinational, so reset must mask them directly: otherwise
    // the reset value FETCH would raise mem_rd (and ir_wen on mem_ready).
    if (!reset) begin
      w_ir_wen   = 1'b0;
      w_pc_en    = 1'b0;
      w_pc_sel   = 1'b0;
      w_mem_rd   = 1'b0;
      w_mem_wr   = 1'b0;
      w_addr_sel = 1'b0;
      w_rf_wen   = 1'b0;
      w_wb_sel   = 1'b0;
      w_imm_sel  = 1'b0;
      w_alu_op   = ALU_NOP;
      w_halted   = 1'b0;
      w_fault    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_clr) begin
        r_wait_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  assign ctl_if.ir_wen   = w_ir_wen;
  assign ctl_if.pc_en    = w_pc_en;
  assign ctl_if.pc_sel   = w_pc_sel;
  assign ctl_if.mem_rd   = w_mem_rd;
  assign ctl_if.mem_wr   = w_mem_wr;
  assign ctl_if.addr_sel = w_addr_sel;
  assign ctl_if.rf_wen   = w_rf_wen;
  assign ctl_if.wb_sel   = w_wb_sel;
  assign ctl_if.imm_sel  = w_imm_sel;
  assign ctl_if.alu_op   = w_alu_op;
  assign ctl_if.halted   = w_halted;
  assign ctl_if.fault    = w_fault;
  assign ctl_if.state    = r_state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_fsm
// Self-checking bench: each instruction is planned as a transaction (fetch
// latency, memory latency, zero flag, halt idle time, optional reset point)
// and the expected per-cycle controller outputs are generated from that plan.
// -----------------------------------------------------------------------------
module tb_cpu_control_fsm;

  localparam int TMO = 4;
  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_MEM = 3, S_HALT = 4, S_FAULT = 5;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_mis = 0;

  cpu_control_fsm_if ifc ();

  cpu_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk    (clk),
    .reset  (reset),
    .ctl_if (ifc)
  );

  always #5 clk = ~clk;

  // {state, ir_wen, pc_en, pc_sel, mem_rd, mem_wr, addr_sel, rf_wen, wb_sel,
  //  imm_sel, alu_op, halted, fault}
  logic [17:0] obs;
  assign obs = {ifc.state, ifc.ir_wen, ifc.pc_en, ifc.pc_sel, ifc.mem_rd, ifc.mem_wr,
                ifc.addr_sel, ifc.rf_wen, ifc.wb_sel, ifc.imm_sel, ifc.alu_op,
                ifc.halted, ifc.fault};

  function automatic logic [17:0] ov(input int st, input bit irw, input bit pce, input bit pcs,
                                     input bit rd, input bit wr, input bit asel, input bit rfw,
                                     input bit wbs, input bit imm, input logic [3:0] aop);
    logic [2:0] s;
    s = 3'(st);
    return {s, irw, pce, pcs, rd, wr, asel, rfw, wbs, imm, aop, bit'(st == S_HALT), bit'(st == S_FAULT)};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=%05h expected=%05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entered at posedge+1; drives inputs, samples at negedge, returns at posedge+1.
  task automatic step(input bit rdy, input bit rn, input logic [17:0] expv, input string tag);
    ifc.mem_ready = rdy;
    ifc.run       = rn;
    @(negedge clk);
    check(tag, 32'(obs), 32'(expv));
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse in the middle of a cycle, held across one edge
  // with mem_ready high so that no ir_wen/rf_wen may leak out.
  task automatic async_reset(input string tag);
    #1 reset = 1'b0;
    #1 check({tag, "_async"}, 32'(obs), 32'(ov(S_FETCH, 0,0,0,0,0,0,0,0,0,4'h0)));
    ifc.mem_ready = 1'b1;
    ifc.run       = 1'b1;
    @(negedge clk);
    check({tag, "_held"}, 32'(obs), 32'(ov(S_FETCH, 0,0,0,0,0,0,0,0,0,4'h0)));
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic fault_tail(input string tag);
    for (int i = 0; i < 3; i++)
      step(rb(), rb(), ov(S_FAULT, 0,0,0,0,0,0,0,0,0,4'h0), tag);
    async_reset({tag, "_rst"});
  endtask

  // One instruction: fdly / mdly = wait cycles before mem_ready in FETCH / MEM,
  // rst_at = MEM wait cycle at which reset is pulsed (-1 = none).
  task automatic run_instr(input logic [15:0] ins, input bit zf, input int fdly, input int mdly,
                           input int halt_idle, input int rst_at);
    logic [3:0] opc;
    logic [3:0] aop;
    bit ld, st, taken, imm;
    opc = ins[15:12];
    ifc.instr     = ins;
    ifc.zero_flag = zf;

    for (int k = 0; k <= fdly; k++) begin
      if (k == fdly) begin
        step(1'b1, rb(), ov(S_FETCH, 1,1,0,1,0,0,0,0,0,4'h0), "fetch_ack");
      end else begin
        step(1'b0, rb(), ov(S_FETCH, 0,0,0,1,0,0,0,0,0,4'h0), "fetch_wait");
        if (k == TMO) begin
          fault_tail("fetch_timeout");
          return;
        end
      end
    end

    step(rb(), rb(), ov(S_DECODE, 0,0,0,0,0,0,0,0,0,4'h0), "decode");

    if (opc <= 4'hB) begin
      imm = (opc != 4'h0);
      aop = imm ? opc : ins[7:4];
      step(rb(), rb(), ov(S_EXEC, 0,0,0,0,0,0,1,0,imm,aop), "exec_alu");
      return;
    end
    if (opc == 4'hE) begin
      taken = !ins[11] || zf;
      step(rb(), rb(), ov(S_EXEC, 0,taken,taken,0,0,0,0,0,0,4'h0), "exec_jump");
      return;
    end
    step(rb(), rb(), ov(S_EXEC, 0,0,0,0,0,0,0,0,0,4'h0), "exec_idle");
    if (opc == 4'hF) begin
      for (int i = 0; i < halt_idle; i++)
        step(rb(), 1'b0, ov(S_HALT, 0,0,0,0,0,0,0,0,0,4'h0), "halt_idle");
      step(rb(), 1'b1, ov(S_HALT, 0,0,0,0,0,0,0,0,0,4'h0), "halt_run");
      return;
    end

    ld = (opc == 4'hC);
    st = (opc == 4'hD);
    for (int k = 0; k <= mdly; k++) begin
      if (k == rst_at) begin
        ifc.mem_ready = 1'b0;
        #1 check("mem_pre_reset", 32'(obs), 32'(ov(S_MEM, 0,0,0,ld,st,1,0,0,0,4'h0)));
        async_reset("mem_reset");
        return;
      end
      if (k == mdly) begin
        step(1'b1, rb(), ov(S_MEM, 0,0,0,ld,st,1,ld,ld,0,4'h0), "mem_ack");
      end else begin
        step(1'b0, rb(), ov(S_MEM, 0,0,0,ld,st,1,0,0,0,4'h0), "mem_wait");
        if (k == TMO) begin
          fault_tail("mem_timeout");
          return;
        end
      end
    end
  endtask

  function automatic int rand_delay();
    if ($urandom_range(0, 15) == 0) return TMO + 1 + int'($urandom_range(0, 2));
    return int'($urandom_range(0, TMO));
  endfunction

  initial begin
    logic [15:0] ins;
    int rst_at;
    reset         = 1'b0;
    ifc.instr     = 16'h0000;
    ifc.mem_ready = 1'b1;
    ifc.zero_flag = 1'b0;
    ifc.run       = 1'b0;
    #1 check("reset_state", 32'(obs), 32'(ov(S_FETCH, 0,0,0,0,0,0,0,0,0,4'h0)));
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed scenarios
    run_instr(16'h1203, 1'b0, 0, 0, 0, -1);        // ADDI
    run_instr(16'hC120, 1'b0, 0, 3, 0, -1);        // LOAD, 3 wait cycles
    run_instr(16'hE800, 1'b0, 0, 0, 0, -1);        // conditional jump, not taken
    run_instr(16'hE800, 1'b1, 0, 0, 0, -1);        // conditional jump, taken
    run_instr(16'hE000, 1'b0, 0, 0, 0, -1);        // unconditional jump
    run_instr(16'h0A50, 1'b0, 1, 0, 0, -1);        // R-type, alu_op = 5
    run_instr(16'hF000, 1'b0, 0, 0, 10, -1);       // HALT, then run
    run_instr(16'h1203, 1'b0, TMO + 1, 0, 0, -1);  // fetch timeout -> FAULT
    run_instr(16'hC000, 1'b0, TMO, TMO, 0, -1);    // ready exactly at the limit
    run_instr(16'hD000, 1'b0, 0, 3, 0, 1);         // reset during STORE
    run_instr(16'hD000, 1'b0, 0, TMO + 2, 0, -1);  // store timeout -> FAULT
    run_instr(16'hD345, 1'b0, 2, 2, 0, -1);        // STORE completes

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      ins    = 16'($urandom());
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TMO)) : -1;
      run_instr(ins, rb(), rand_delay(), rand_delay(), int'($urandom_range(0, 4)), rst_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
